// File: rtl/mdio_mgmt_sched.sv
`default_nettype none
// ============================================================================
// Module      : mdio_mgmt_sched
// Description : Management-plane scheduler in front of a single MDIO master.
//               Arbitrates between a host command port and an autonomous PHY
//               status poller. It builds the 16-bit MDIO command word and
//               drives single-beat bus accesses (data, command, then read-back
//               for reads). It publishes the polled status word and a link-up
//               flag.
// Ports       : i_Clk, i_ARst_L            clock, async active-low reset
//               o_Cyc/o_Stb/o_WEn/o2_Addr  bus request to the MDIO master
//               o32_WrData, i_Ack,         bus write data, acknowledge,
//               i32_RdData                 and read data ([15:0] used)
//               i_HReq/i_HWr/i5_HPhy/      host request, operation and
//               i5_HReg/i16_HWrData        addresses/data
//               o_HBusy/o_HDone/           host status and read result
//               o16_HRdData
//               o16_PollData/o_PollValid/  polled value, update pulse and
//               o_LinkUp                   link flag (bit 2)
// Revision    : 1.0 - initial release
// ============================================================================
module mdio_mgmt_sched #(
  parameter logic [4:0]  POLL_PHY     = 5'd0,
  parameter logic [4:0]  POLL_REG     = 5'd1,
  parameter logic [19:0] POLL_PERIOD  = 20'd100000,
  parameter logic [10:0] FRAME_CYCLES = 11'd1100
) (
  input  logic        i_Clk,
  input  logic        i_ARst_L,
  output logic        o_Cyc,
  output logic        o_Stb,
  output logic        o_WEn,
  output logic [1:0]  o2_Addr,
  output logic [31:0] o32_WrData,
  input  logic        i_Ack,
  input  logic [31:0] i32_RdData,
  input  logic        i_HReq,
  input  logic        i_HWr,
  input  logic [4:0]  i5_HPhy,
  input  logic [4:0]  i5_HReg,
  input  logic [15:0] i16_HWrData,
  output logic        o_HBusy,
  output logic        o_HDone,
  output logic [15:0] o16_HRdData,
  output logic [15:0] o16_PollData,
  output logic        o_PollValid,
  output logic        o_LinkUp
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_CMD  = 3'd2,
    S_WAIT    = 3'd3,
    S_RD      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, state_next;

  // Latched host request
  logic        host_pend;
  logic        h_wr;
  logic [4:0]  h_phy, h_reg;
  logic [15:0] h_data;

  // Poll timer
  logic [19:0] poll_cnt;
  logic        poll_pend;
  logic        poll_wrap;

  // Round-robin preference, only consulted when both requesters are pending
  logic        prefer_poll;

  // Transaction in flight
  logic        cur_poll, cur_wr;
  logic [4:0]  cur_phy, cur_reg;
  logic [15:0] cur_data;
  logic [10:0] frame_cnt;

  // Combinational arbitration and transaction selection
  logic        grant_host, grant_poll;
  logic        nxt_wr;
  logic [4:0]  nxt_phy, nxt_reg;
  logic [15:0] nxt_data;
  logic [15:0] cmd_word;

  logic        unused_rd_hi;
  assign unused_rd_hi = ^i32_RdData[31:16];

  assign poll_wrap = (poll_cnt == (POLL_PERIOD - 20'd1));
  assign cmd_word  = {2'b01, (nxt_wr ? 2'b01 : 2'b10), nxt_phy, nxt_reg, 2'b10};

  always_comb begin
    grant_host = 1'b0;
    grant_poll = 1'b0;
    if (state == S_IDLE) begin
      if (host_pend && (!poll_pend || !prefer_poll)) begin
        grant_host = 1'b1;
      end else if (poll_pend) begin
        grant_poll = 1'b1;
      end
    end

    // In IDLE the bus registers are loaded from the winner's fields on the
    // grant edge; in every other state the latched transaction is used.
    nxt_wr   = cur_wr;
    nxt_phy  = cur_phy;
    nxt_reg  = cur_reg;
    nxt_data = cur_data;
    if (grant_host) begin
      nxt_wr   = h_wr;
      nxt_phy  = h_phy;
      nxt_reg  = h_reg;
      nxt_data = h_data;
    end else if (grant_poll) begin
      nxt_wr   = 1'b0;
      nxt_phy  = POLL_PHY;
      nxt_reg  = POLL_REG;
      nxt_data = 16'h0000;
    end

    state_next = state;
    case (state)
      S_IDLE:    if (grant_host || grant_poll) state_next = nxt_wr ? S_WR_DATA : S_WR_CMD;
      S_WR_DATA: if (i_Ack) state_next = S_WR_CMD;
      S_WR_CMD:  if (i_Ack) state_next = S_WAIT;
      S_WAIT:    if (frame_cnt == (FRAME_CYCLES - 11'd1)) state_next = cur_wr ? S_DONE : S_RD;
      S_RD:      if (i_Ack) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bus request registers follow the next state, so they are valid in the
  // first cycle of an access state, stay up through the ack cycle (the
  // command strobe/ack coincidence launches the frame) and drop afterwards.
  // WR_DATA -> WR_CMD runs back-to-back with the new address and data.
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      o_Cyc      <= 1'b0;
      o_Stb      <= 1'b0;
      o_WEn      <= 1'b0;
      o2_Addr    <= 2'b00;
      o32_WrData <= 32'h0;
    end else begin
      o_Cyc      <= 1'b0;
      o_Stb      <= 1'b0;
      o_WEn      <= 1'b0;
      o2_Addr    <= 2'b00;
      o32_WrData <= 32'h0;
      case (state_next)
        S_WR_DATA: begin
          o_Cyc      <= 1'b1;
          o_Stb      <= 1'b1;
          o_WEn      <= 1'b1;
          o2_Addr    <= 2'b01;
          o32_WrData <= {16'h0000, nxt_data};
        end
        S_WR_CMD: begin
          o_Cyc      <= 1'b1;
          o_Stb      <= 1'b1;
          o_WEn      <= 1'b1;
          o2_Addr    <= 2'b00;
          o32_WrData <= {16'h0000, cmd_word};
        end
        S_RD: begin
          o_Cyc      <= 1'b1;
          o_Stb      <= 1'b1;
          o2_Addr    <= 2'b10;
        end
        default: ;
      endcase
    end
  end

  // Request capture, pending flags, poll timer and transaction latch
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      host_pend   <= 1'b0;
      h_wr        <= 1'b0;
      h_phy       <= 5'd0;
      h_reg       <= 5'd0;
      h_data      <= 16'h0000;
      poll_cnt    <= 20'd0;
      poll_pend   <= 1'b0;
      prefer_poll <= 1'b0;
      cur_poll    <= 1'b0;
      cur_wr      <= 1'b0;
      cur_phy     <= 5'd0;
      cur_reg     <= 5'd0;
      cur_data    <= 16'h0000;
      frame_cnt   <= 11'd0;
    end else begin
      // host_pend is only set while o_HBusy is low and only granted while
      // it is high, so accept and grant never coincide.
      if (grant_host) begin
        host_pend <= 1'b0;
      end else if (i_HReq && !o_HBusy) begin
        host_pend <= 1'b1;
        h_wr      <= i_HWr;
        h_phy     <= i5_HPhy;
        h_reg     <= i5_HReg;
        h_data    <= i16_HWrData;
      end

      poll_cnt <= poll_wrap ? 20'd0 : (poll_cnt + 20'd1);
      // An expiry while a poll is already pending is dropped, not queued.
      if (grant_poll) begin
        poll_pend <= 1'b0;
      end else if (poll_wrap) begin
        poll_pend <= 1'b1;
      end

      // The preference flips only on a contended grant, so consecutive
      // collisions alternate winners regardless of uncontended traffic.
      if (grant_host && poll_pend) begin
        prefer_poll <= 1'b1;
      end else if (grant_poll && host_pend) begin
        prefer_poll <= 1'b0;
      end

      if (grant_host || grant_poll) begin
        cur_poll <= grant_poll;
        cur_wr   <= nxt_wr;
        cur_phy  <= nxt_phy;
        cur_reg  <= nxt_reg;
        cur_data <= nxt_data;
      end

      frame_cnt <= (state == S_WAIT) ? (frame_cnt + 11'd1) : 11'd0;
    end
  end

  // Result delivery; the values appear during the DONE cycle
  always_ff @(posedge i_Clk or negedge i_ARst_L) begin
    if (!i_ARst_L) begin
      o_HBusy      <= 1'b0;
      o_HDone      <= 1'b0;
      o16_HRdData  <= 16'h0000;
      o16_PollData <= 16'h0000;
      o_PollValid  <= 1'b0;
      o_LinkUp     <= 1'b0;
    end else begin
      o_HDone     <= 1'b0;
      o_PollValid <= 1'b0;
      if (state_next == S_DONE) begin
        if (cur_poll) begin
          o16_PollData <= i32_RdData[15:0];
          o_LinkUp     <= i32_RdData[2];
          o_PollValid  <= 1'b1;
        end else begin
          o_HDone <= 1'b1;
          o_HBusy <= 1'b0;
          if (!cur_wr) begin
            o16_HRdData <= i32_RdData[15:0];
          end
        end
      end else if (i_HReq && !o_HBusy) begin
        o_HBusy <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdio_mgmt_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdio_mgmt_sched
// Description : Scoreboard bench for mdio_mgmt_sched. Stimulus pushes the
//               expected bus accesses, host results and poll results; a
//               negedge monitor pops and compares as the DUT presents them.
//               A bus-slave model acks one clock after the strobe and can
//               stall read acks to force request collisions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdio_mgmt_sched;

  localparam int PERIOD = 2000;
  localparam int FRAME  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_Cyc, o_Stb, o_WEn;
  logic [1:0]  o2_Addr;
  logic [31:0] o32_WrData;
  logic        ack;
  logic [31:0] rd_data;
  logic        i_HReq = 1'b0, i_HWr = 1'b0;
  logic [4:0]  i5_HPhy = 5'd0, i5_HReg = 5'd0;
  logic [15:0] i16_HWrData = 16'h0;
  logic        o_HBusy, o_HDone, o_PollValid, o_LinkUp;
  logic [15:0] o16_HRdData, o16_PollData;

  logic [15:0] phy_rd = 16'h0;
  int          stall_len = 0;
  int          rd_wait;

  always #5 clk = ~clk;

  mdio_mgmt_sched #(
    .POLL_PHY(5'd0), .POLL_REG(5'd1),
    .POLL_PERIOD(20'(PERIOD)), .FRAME_CYCLES(11'(FRAME))
  ) dut (
    .i_Clk(clk), .i_ARst_L(rst_n),
    .o_Cyc(o_Cyc), .o_Stb(o_Stb), .o_WEn(o_WEn), .o2_Addr(o2_Addr),
    .o32_WrData(o32_WrData), .i_Ack(ack), .i32_RdData(rd_data),
    .i_HReq(i_HReq), .i_HWr(i_HWr), .i5_HPhy(i5_HPhy), .i5_HReg(i5_HReg),
    .i16_HWrData(i16_HWrData), .o_HBusy(o_HBusy), .o_HDone(o_HDone),
    .o16_HRdData(o16_HRdData), .o16_PollData(o16_PollData),
    .o_PollValid(o_PollValid), .o_LinkUp(o_LinkUp)
  );

  // Upper half set to ones: the DUT must ignore it
  assign rd_data = {16'hFFFF, phy_rd};

  // Slave: acks one clock after the strobe; reads wait stall_len extra clocks
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack     <= 1'b0;
      rd_wait <= 0;
    end else begin
      ack <= 1'b0;
      if (o_Cyc && o_Stb && !ack) begin
        if (o_WEn || rd_wait >= stall_len) begin
          ack     <= 1'b1;
          rd_wait <= 0;
        end else begin
          rd_wait <= rd_wait + 1;
        end
      end
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] data;
  } bus_t;
  typedef struct {
    logic [15:0] data;
    logic        link;
    int          interval;
  } poll_t;

  bus_t        exp_bus[$];
  logic [15:0] exp_host[$];
  poll_t       exp_poll[$];

  int n_tests = 0, n_fail = 0;
  int timeouts = 0, tmo_seen = 0;
  int cyc_n = 0, last_poll = 0;
  bit final_req = 1'b0, final_done = 1'b0;
  bus_t        eb;
  poll_t       ep;
  logic [15:0] eh;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc_n++;
    if (timeouts != tmo_seen) begin
      n_tests += timeouts - tmo_seen;
      n_fail  += timeouts - tmo_seen;
      tmo_seen = timeouts;
    end
    if (!rst_n) begin
      n_tests++;
      if ({o_Cyc, o_Stb, o_WEn, o2_Addr, o32_WrData, o_HBusy, o_HDone,
           o16_HRdData, o16_PollData, o_PollValid, o_LinkUp} != '0) begin
        n_fail++;
        $display("FAIL reset_state: outputs=%h required all 0",
                 {o_Cyc, o_Stb, o_WEn, o2_Addr, o32_WrData, o_HBusy, o_HDone,
                  o16_HRdData, o16_PollData, o_PollValid, o_LinkUp});
      end
    end else begin
      if (o_Cyc && o_Stb && ack) begin
        n_tests++;
        if (exp_bus.size() == 0) begin
          n_fail++;
          $display("FAIL bus_unexpected: got we=%0b addr=%0d data=%h, required no access",
                   o_WEn, o2_Addr, o32_WrData);
        end else begin
          eb = exp_bus.pop_front();
          if (o_WEn !== eb.we || o2_Addr !== eb.addr || (eb.we && o32_WrData !== eb.data)) begin
            n_fail++;
            $display("FAIL bus_access: got we=%0b addr=%0d data=%h, required we=%0b addr=%0d data=%h",
                     o_WEn, o2_Addr, o32_WrData, eb.we, eb.addr, eb.data);
          end
        end
      end
      if (o_HDone) begin
        n_tests++;
        if (exp_host.size() == 0) begin
          n_fail++;
          $display("FAIL hdone_unexpected: got o_HDone=1 rd=%h, required no completion", o16_HRdData);
        end else begin
          eh = exp_host.pop_front();
          if (o16_HRdData !== eh || o_HBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL host_result: got rd=%h busy=%0b, required rd=%h busy=0",
                     o16_HRdData, o_HBusy, eh);
          end
        end
      end
      if (o_PollValid) begin
        n_tests++;
        if (exp_poll.size() == 0) begin
          n_fail++;
          $display("FAIL poll_unexpected: got data=%h, required no poll result", o16_PollData);
        end else begin
          ep = exp_poll.pop_front();
          if (o16_PollData !== ep.data || o_LinkUp !== ep.link ||
              (ep.interval != 0 && (cyc_n - last_poll) != ep.interval)) begin
            n_fail++;
            $display("FAIL poll_result: got data=%h link=%0b gap=%0d, required data=%h link=%0b gap=%0d",
                     o16_PollData, o_LinkUp, cyc_n - last_poll, ep.data, ep.link, ep.interval);
          end
        end
        last_poll = cyc_n;
      end
    end
    if (final_req && !final_done) begin
      final_done = 1'b1;
      n_tests++;
      if (exp_bus.size() != 0 || exp_host.size() != 0 || exp_poll.size() != 0) begin
        n_fail++;
        $display("FAIL final_drain: left bus=%0d host=%0d poll=%0d, required 0 0 0",
                 exp_bus.size(), exp_host.size(), exp_poll.size());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic void push_bus(input logic we, input logic [1:0] addr, input logic [31:0] data);
    bus_t b;
    b.we = we; b.addr = addr; b.data = data;
    exp_bus.push_back(b);
  endfunction

  function automatic void push_poll(input logic [15:0] data, input logic link, input int interval);
    poll_t p;
    p.data = data; p.link = link; p.interval = interval;
    exp_poll.push_back(p);
  endfunction

  task automatic host_req(input logic wr, input logic [4:0] phy, input logic [4:0] rga,
                          input logic [15:0] d);
    @(negedge clk); #1;
    i_HReq = 1'b1; i_HWr = wr; i5_HPhy = phy; i5_HReg = rga; i16_HWrData = d;
    @(negedge clk); #1;
    i_HReq = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string what);
    int k;
    k = 0;
    while ((exp_bus.size() != 0 || exp_host.size() != 0 || exp_poll.size() != 0) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (exp_bus.size() != 0 || exp_host.size() != 0 || exp_poll.size() != 0) begin
      $display("FAIL timeout_%s: pending bus=%0d host=%0d poll=%0d, required 0",
               what, exp_bus.size(), exp_host.size(), exp_poll.size());
      timeouts++;
    end
  endtask

  task automatic wait_read(input int bound, input bit need_ack, input string what);
    int k;
    k = 0;
    while (!(o_Cyc && !o_WEn && (ack || !need_ack)) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (!(o_Cyc && !o_WEn && (ack || !need_ack))) begin
      $display("FAIL timeout_%s: no read access within %0d cycles, required one", what, bound);
      timeouts++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;

    // Host read phy=3 reg=1: command 01_10_00011_00001_10 = 0x6186
    phy_rd = 16'h796D;
    push_bus(1'b1, 2'b00, 32'h0000_6186);
    push_bus(1'b0, 2'b10, 32'h0);
    exp_host.push_back(16'h796D);
    host_req(1'b0, 5'd3, 5'd1, 16'h0);
    wait_drain(200, "host_read");
    repeat (3) @(negedge clk);

    // Host write phy=0 reg=0 data 0x1140: command 0x5002, read result unchanged
    push_bus(1'b1, 2'b01, 32'h0000_1140);
    push_bus(1'b1, 2'b00, 32'h0000_5002);
    exp_host.push_back(16'h796D);
    host_req(1'b1, 5'd0, 5'd0, 16'h1140);
    wait_drain(200, "host_write");
    repeat (3) @(negedge clk);

    // Busy rejection: phy=2 reg=5 read (0x6116); second request is ignored
    phy_rd = 16'h1234;
    push_bus(1'b1, 2'b00, 32'h0000_6116);
    push_bus(1'b0, 2'b10, 32'h0);
    exp_host.push_back(16'h1234);
    host_req(1'b0, 5'd2, 5'd5, 16'h0);
    repeat (3) @(negedge clk);
    host_req(1'b1, 5'd7, 5'd7, 16'hDEAD);
    wait_drain(200, "busy_reject");
    repeat (60) @(negedge clk);

    // Polls of phy=0 reg=1 (0x6006) every PERIOD clocks
    phy_rd = 16'h0004;
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h0004, 1'b1, 0);
    wait_drain(2500, "poll1");
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h0004, 1'b1, PERIOD);
    wait_drain(2500, "poll2");
    phy_rd = 16'h0000;
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h0000, 1'b0, PERIOD);
    wait_drain(2500, "poll3");

    // Collision 1: stall a poll read past the next expiry, host write meanwhile.
    // Host (phy=4 reg=31 -> 0x527E) must win, then the pending poll.
    phy_rd = 16'h0024;
    stall_len = 2500;
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h0024, 1'b1, 0);
    wait_read(2500, 1'b0, "coll1_start");
    repeat (10) @(negedge clk);
    push_bus(1'b1, 2'b01, 32'h0000_A5A5);
    push_bus(1'b1, 2'b00, 32'h0000_527E);
    exp_host.push_back(16'h1234);
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h0024, 1'b1, 0);
    host_req(1'b1, 5'd4, 5'd31, 16'hA5A5);
    wait_read(3000, 1'b1, "coll1_ack");
    stall_len = 0;
    wait_drain(1000, "coll1");

    // Collision 2: stall across two expiries (second dropped), host read
    // phy=1 reg=1 (0x6086). Poll wins this time; exactly one poll queued.
    phy_rd = 16'h796B;
    stall_len = 4500;
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h796B, 1'b0, 0);
    wait_read(2500, 1'b0, "coll2_start");
    repeat (10) @(negedge clk);
    push_bus(1'b1, 2'b00, 32'h0000_6006);
    push_bus(1'b0, 2'b10, 32'h0);
    push_poll(16'h796B, 1'b0, 0);
    push_bus(1'b1, 2'b00, 32'h0000_6086);
    push_bus(1'b0, 2'b10, 32'h0);
    exp_host.push_back(16'h796B);
    host_req(1'b0, 5'd1, 5'd1, 16'h0);
    wait_read(5000, 1'b1, "coll2_ack");
    stall_len = 0;
    wait_drain(1000, "coll2");
    repeat (500) @(negedge clk);

    // Reset while waiting for the frame: no completion for the aborted read
    push_bus(1'b1, 2'b00, 32'h0000_6186);
    host_req(1'b0, 5'd3, 5'd1, 16'h0);
    wait_drain(100, "abort_cmd");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal read afterwards
    phy_rd = 16'h5A5A;
    push_bus(1'b1, 2'b00, 32'h0000_6086);
    push_bus(1'b0, 2'b10, 32'h0);
    exp_host.push_back(16'h5A5A);
    host_req(1'b0, 5'd1, 5'd1, 16'h0);
    wait_drain(200, "post_reset_read");
    repeat (5) @(negedge clk);

    final_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
